gate_out_filter: RTL and testbench
==================================

GATE_OUT_FILTER -- requirements
Module: gate_out_filter

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2: synchronizer flop count on din, legal range 2..4.
REQ-002 SHALL provide parameter STABLE_CYCLES, default 4: consecutive stable synchronized cycles required before dout changes, legal range 1..255.
REQ-003 SHALL provide parameter CNT_W, default 8: width of the edge counter carried in evt_data.
REQ-004 SHALL have exactly one clock; reset is synchronous and active-high.
REQ-005 SHALL provide clk, input, 1 bit: the sole clock; all state updates on its rising edge.
REQ-006 SHALL provide rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL provide din, input, 1 bit: raw, possibly glitching level from the upstream primitive-gate network (and/or netlist output).
REQ-008 SHALL provide dout, output, 1 bit: filtered, registered level.
REQ-009 SHALL provide rise_pulse, output, 1 bit: single-cycle pulse when dout goes 0->1.
REQ-010 SHALL provide fall_pulse, output, 1 bit: single-cycle pulse when dout goes 1->0.
REQ-011 SHALL provide evt_valid, output, 1 bit: the event buffer holds an event.
REQ-012 SHALL provide evt_ready, input, 1 bit: the consumer accepts the event.
REQ-013 SHALL provide evt_data, output, CNT_W+1 bits: bit CNT_W is edge type (1 = rise), bits CNT_W-1:0 are the edge count.
REQ-014 SHALL provide overflow, output, 1 bit: sticky flag set when an event is dropped.

Function
REQ-015 SHALL pass din through SYNC_STAGES flops; the last stage is din_s.
REQ-016 SHALL implement the FSM states LOW_STABLE, QUAL_HIGH, HIGH_STABLE and QUAL_LOW, with a stability counter.
- LOW_STABLE with din_s=1 -> QUAL_HIGH, counter=1.
- QUAL_HIGH with din_s=0 -> LOW_STABLE; with din_s=1 and counter=STABLE_CYCLES -> HIGH_STABLE, otherwise counter+1.
- HIGH_STABLE and QUAL_LOW are symmetric.
REQ-017 SHALL set dout=1 registered on entry to HIGH_STABLE and dout=0 on entry to LOW_STABLE.
- Latency from the first clk edge sampling a stable new din to the dout change is SYNC_STAGES+STABLE_CYCLES cycles.
REQ-018 SHALL assert rise_pulse or fall_pulse in the same cycle dout changes, for exactly one cycle.
REQ-019 SHALL never change dout on a din pulse shorter than STABLE_CYCLES synchronized cycles.
REQ-020 SHALL increment the edge counter on every dout change and wrap from 2^CNT_W-1 to 0.
- The value captured into evt_data is the post-increment count.
REQ-021 SHALL use a one-entry event buffer. On a dout change:
- buffer empty -> load the event and set evt_valid=1 in the next cycle.
- buffer full with evt_ready=1 in the same cycle -> replace the buffer with the new event; evt_valid stays 1.
- buffer full with evt_ready=0 -> drop the new event, keep the held event, set overflow=1.
REQ-022 SHALL clear evt_valid the cycle after evt_valid&&evt_ready when no new event arrives.
REQ-023 SHALL hold evt_data stable while evt_valid=1 and evt_ready=0.
REQ-024 SHALL keep overflow set until rst; the edge counter still increments for dropped events.

Reset
REQ-025 SHALL, on rst=1 at a clk edge, apply the following reset state:
- synchronizer flops=0, FSM=LOW_STABLE, counter=0
- dout=0, rise_pulse=0, fall_pulse=0
- evt_valid=0, evt_data=0, edge count=0, overflow=0
REQ-026 SHALL, on rst mid-qualification or with a pending event, discard all state with no pulse or event emitted.
REQ-027 SHALL emit no edge after reset deassertion if din is held 0.

Configuration
REQ-028 SHALL compile the event buffer, edge counter and overflow only when macro GATE_OUT_FILTER_EVT_EN is defined.
REQ-029 SHALL, without GATE_OUT_FILTER_EVT_EN:
- retain all ports
- drive evt_valid=0, evt_data=0 and overflow=0 constantly
- ignore evt_ready
- leave dout, rise_pulse and fall_pulse behaviour unchanged.

Verification
REQ-030 SHALL cover: defaults, rst 2 cycles, din 0->1 held 10 cycles -> dout rises exactly 6 cycles after the first sampling edge; rise_pulse high 1 cycle; evt_data=0x101 (rise, count 1).
REQ-031 SHALL cover: din 1-cycle and 3-cycle high glitches from dout=0 -> dout, pulses and evt_valid stay 0.
REQ-032 SHALL cover: evt_ready=0, two clean edges (rise then fall) -> first event held (0x101), second dropped, overflow=1; then evt_ready=1 -> evt_valid drops next cycle.
REQ-033 SHALL cover: event pending with evt_ready=1 in the same cycle as a fall edge -> evt_valid stays 1 and evt_data=0x002 (fall, count 2); overflow stays 0.
REQ-034 SHALL cover: 256 clean edges with evt_ready=1 -> the count wraps to 0 on edge 256; rst asserted during QUAL_HIGH -> dout=0, no rise_pulse.
REQ-035 SHALL cover: build without GATE_OUT_FILTER_EVT_EN, repeat REQ-030 -> identical dout and pulse timing, evt_valid=0 throughout.

Source files
------------

// File: rtl/gate_out_filter.sv
// gate_out_filter: synchronize and debounce a glitchy gate-network level, emit edge pulses and optional edge events.
// Event buffer, edge counter and overflow are built only with GATE_OUT_FILTER_EVT_EN defined.
module gate_out_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           din,
  output logic           dout,
  output logic           rise_pulse,
  output logic           fall_pulse,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [CNT_W:0] evt_data,
  output logic           overflow
);
  typedef enum logic [1:0] {LOW_STABLE, QUAL_HIGH, HIGH_STABLE, QUAL_LOW} state_t;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_din_s;
  state_t                 r_state;
  logic [7:0]             r_cnt;
  assign w_din_s = r_sync[SYNC_STAGES-1];
  always_ff @(posedge clk)
    r_sync <= rst ? '0 : {r_sync[SYNC_STAGES-2:0], din};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= LOW_STABLE;
      r_cnt      <= '0;
      dout       <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (r_state)
        LOW_STABLE:
          if (w_din_s) begin
            r_state <= QUAL_HIGH;
            r_cnt   <= 8'd1;
          end
        QUAL_HIGH:
          if (!w_din_s) r_state <= LOW_STABLE;
          else if (r_cnt == 8'(STABLE_CYCLES)) begin
            r_state    <= HIGH_STABLE;
            dout       <= 1'b1;
            rise_pulse <= 1'b1;
          end else r_cnt <= r_cnt + 8'd1;
        HIGH_STABLE:
          if (!w_din_s) begin
            r_state <= QUAL_LOW;
            r_cnt   <= 8'd1;
          end
        QUAL_LOW:
          if (w_din_s) r_state <= HIGH_STABLE;
          else if (r_cnt == 8'(STABLE_CYCLES)) begin
            r_state    <= LOW_STABLE;
            dout       <= 1'b0;
            fall_pulse <= 1'b1;
          end else r_cnt <= r_cnt + 8'd1;
      endcase
    end
  end
`ifdef GATE_OUT_FILTER_EVT_EN
  logic [CNT_W-1:0] r_edges;
  logic [CNT_W-1:0] w_edges_n;
  logic             w_edge;
  logic             r_evt_valid;
  logic [CNT_W:0]   r_evt_data;
  logic             r_ovf;
  assign w_edge    = rise_pulse | fall_pulse;
  assign w_edges_n = r_edges + CNT_W'(1);
  // A new edge may replace the held event only when the consumer takes it in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_edges     <= '0;
      r_evt_valid <= 1'b0;
      r_evt_data  <= '0;
      r_ovf       <= 1'b0;
    end else if (w_edge) begin
      r_edges <= w_edges_n;
      if (!r_evt_valid || evt_ready) begin
        r_evt_valid <= 1'b1;
        r_evt_data  <= {rise_pulse, w_edges_n};
      end else r_ovf <= 1'b1;
    end else if (evt_ready) r_evt_valid <= 1'b0;
  end
  assign evt_valid = r_evt_valid;
  assign evt_data  = r_evt_data;
  assign overflow  = r_ovf;
`else
  logic w_unused;
  assign w_unused  = evt_ready;
  assign evt_valid = 1'b0;
  assign evt_data  = '0;
  assign overflow  = 1'b0;
`endif
endmodule

// File: tb/tb_gate_out_filter.sv
// tb_gate_out_filter: table-driven glitch vectors plus directed edge/event sequences with an event scoreboard.
module tb_gate_out_filter;
`ifdef GATE_OUT_FILTER_EVT_EN
  localparam bit EVT = 1'b1;
`else
  localparam bit EVT = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst, din, evt_ready;
  logic       dout, rise_pulse, fall_pulse, evt_valid, overflow;
  logic [8:0] evt_data;
  logic [8:0] q[$];
  logic [7:0] exp_cnt;
  int         checks = 0;
  int         failures = 0;
  typedef struct {int hi; int lo; int exp_edges;} vec_t;
  vec_t vecs[5];
  gate_out_filter dut (
    .clk(clk), .rst(rst), .din(din), .dout(dout), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_data(evt_data), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    din = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_cnt = '0;
    q.delete();
  endtask
  task automatic push_evt(input logic lvl);
    exp_cnt = exp_cnt + 8'd1;
    if (EVT) q.push_back({lvl, exp_cnt});
  endtask
  task automatic step_edge(input logic lvl);
    push_evt(lvl);
    din = lvl;
    repeat (7) tick();
    chk("step_dout", dout, lvl);
    chk("step_pulse", {rise_pulse, fall_pulse}, lvl ? 2'b10 : 2'b01);
    tick();
  endtask
  always @(negedge clk) begin
    if (EVT) begin
      if (!rst && evt_valid && evt_ready) begin
        if (q.size() == 0) chk("evt_unexpected", evt_data, 9'h1ff);
        else chk("evt_sb", evt_data, q.pop_front());
      end
    end else chk("evt_off", {evt_valid, overflow, evt_data}, 0);
  end
  initial begin
    int nr, nf;
    vecs[0] = '{1, 12, 0};
    vecs[1] = '{3, 12, 0};
    vecs[2] = '{4, 12, 0};
    vecs[3] = '{5, 12, 1};
    vecs[4] = '{10, 12, 1};
    evt_ready = 1'b0;
    do_reset();
    tick();
    chk("rst_dout", dout, 0);
    chk("rst_pulses", {rise_pulse, fall_pulse}, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_data", evt_data, 0);
    chk("rst_overflow", overflow, 0);
    // rise latency: first sampling edge, then dout changes on the 6th following edge
    din = 1'b1;
    exp_cnt = exp_cnt + 8'd1;
    nr = 0;
    repeat (6) begin
      tick();
      nr += int'(dout) + int'(rise_pulse);
    end
    chk("lat_early", nr, 0);
    tick();
    chk("lat_dout", dout, 1);
    chk("lat_rise", rise_pulse, 1);
    tick();
    chk("lat_rise_1cyc", rise_pulse, 0);
    chk("lat_evt_valid", evt_valid, EVT);
    chk("lat_evt_data", evt_data, EVT ? 9'h101 : 9'h000);
    repeat (2) tick();
    din = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    repeat (7) tick();
    chk("ovf_fall", {dout, fall_pulse}, 2'b01);
    tick();
    chk("ovf_flag", overflow, EVT);
    chk("ovf_held", evt_data, EVT ? 9'h101 : 9'h000);
    if (EVT) q.push_back(9'h101);
    evt_ready = 1'b1;
    tick();
    chk("ovf_drain", evt_valid, 0);
    chk("ovf_sticky", overflow, EVT);
    do_reset();
    foreach (vecs[i]) begin
      if (vecs[i].exp_edges != 0) begin
        push_evt(1'b1);
        push_evt(1'b0);
      end
      nr = 0;
      nf = 0;
      din = 1'b1;
      repeat (vecs[i].hi) begin
        tick();
        nr += int'(rise_pulse);
        nf += int'(fall_pulse);
      end
      din = 1'b0;
      repeat (vecs[i].lo) begin
        tick();
        nr += int'(rise_pulse);
        nf += int'(fall_pulse);
      end
      chk($sformatf("glitch%0d_rise", vecs[i].hi), nr, vecs[i].exp_edges);
      chk($sformatf("glitch%0d_fall", vecs[i].hi), nf, vecs[i].exp_edges);
      chk($sformatf("glitch%0d_dout", vecs[i].hi), dout, 0);
    end
    // consumer takes the held rise in the very cycle the fall event arrives
    do_reset();
    evt_ready = 1'b0;
    din = 1'b1;
    exp_cnt = exp_cnt + 8'd1;
    repeat (8) tick();
    chk("rep_held", {evt_valid, evt_data}, EVT ? 10'h301 : 10'h000);
    din = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    repeat (7) tick();
    chk("rep_fall", fall_pulse, 1);
    if (EVT) begin
      q.push_back(9'h101);
      q.push_back(9'h002);
    end
    evt_ready = 1'b1;
    tick();
    chk("rep_valid", evt_valid, EVT);
    chk("rep_data", evt_data, EVT ? 9'h002 : 9'h000);
    chk("rep_no_ovf", overflow, 0);
    tick();
    for (int k = 3; k <= 256; k++) step_edge(k[0]);
    chk("wrap_data", {evt_valid, evt_data}, EVT ? 10'h200 : 10'h000);
    chk("wrap_dout", dout, 0);
    tick();
    // reset while qualifying a rise discards it
    din = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    din = 1'b0;
    tick();
    rst = 1'b0;
    q.delete();
    nr = 0;
    repeat (14) begin
      tick();
      nr += int'(rise_pulse) + int'(fall_pulse) + int'(dout) + int'(evt_valid);
    end
    chk("rstq_quiet", nr, 0);
    chk("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
